rst_gen: RTL and testbench



---
 rtl/rst_gen.sv | 136 +++++++++++++
 tb/tb_rst_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_gen.sv
// Board reset generator: merges power-on, debounced button, software request and optional
// watchdog into one stretched active-low reset, and records the cause. Watchdog: RST_GEN_WDT_EN.
module rst_gen #(
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 32,
  parameter int WDT_CYCLES  = 1024,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n,
  input  logic       swrst_req,
  input  logic       wdt_kick,
  output logic       swrst_ack,
  output logic       rstout_n,
  output logic [1:0] rst_cause
);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [CNT_W-1:0] deb_cnt;
  logic [1:0]       cause_nxt;
  logic             ack_nxt;
  logic             btn_meta, btn_sync;
  logic             btn_pressed;
  logic             wdt_expire;

  // Button synchronizer idles released so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b1;
      btn_sync <= 1'b1;
    end else begin
      btn_meta <= btn_n;
      btn_sync <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
    end else if (btn_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt <= deb_cnt + ONE;
    end
  end

  assign btn_pressed = (deb_cnt == DEB_MAX);

`ifdef RST_GEN_WDT_EN
  logic [CNT_W-1:0] wdt_cnt;

  // A kick in the expiry cycle wins over the timeout.
  assign wdt_expire = (state == RUN) && (wdt_cnt == WDT_LAST) && !wdt_kick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if ((state != RUN) || (state_nxt != RUN) || wdt_kick) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + ONE;
    end
  end
`else
  logic unused_wdt;

  assign wdt_expire = 1'b0;
  assign unused_wdt = ^{wdt_kick, WDT_LAST};
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    cause_nxt = rst_cause;
    ack_nxt   = 1'b0;
    case (state)
      HOLD: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + ONE;
        end else if (!btn_pressed) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        hold_nxt = '0;
        // Priority button > watchdog > software; losers are simply dropped.
        if (btn_pressed) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_BTN;
        end else if (wdt_expire) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_WDT;
        end else if (swrst_req) begin
          state_nxt = HOLD;
          cause_nxt = CAUSE_SW;
          ack_nxt   = 1'b1;
        end
      end
      default: state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      rstout_n  <= 1'b0;
      swrst_ack <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      rstout_n  <= (state_nxt == RUN);
      swrst_ack <= ack_nxt;
      rst_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_rst_gen.sv
// Self-checking bench for rst_gen: cycle model of the reset rules plus directed literal checks.
// Build with RST_GEN_WDT_EN defined to exercise the watchdog.
module tb_rst_gen;

  localparam int DEB  = 16;
  localparam int HOLD = 32;
  localparam int WDT  = 1024;
`ifdef RST_GEN_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_n;
  logic       swrst_req;
  logic       wdt_kick;
  logic       swrst_ack;
  logic       rstout_n;
  logic [1:0] rst_cause;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit auto_kick = 1'b1;
  bit check_en  = 1'b0;

  int low_run    = 0;
  int last_width = 0;
  int fall_count = 0;
  int ack_count  = 0;

  typedef enum {M_HOLD, M_RUN} mstate_e;

  // lr0..lr2: raw btn_n low-run lengths from the last three edges (sync delay is two edges).
  typedef struct {
    mstate_e    state;
    int         low_len;
    int         idle;
    int         lr0, lr1, lr2;
    logic [1:0] cause;
    bit         ack;
  } model_t;

  model_t m;

  rst_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_n     (btn_n),
    .swrst_req (swrst_req),
    .wdt_kick  (wdt_kick),
    .swrst_ack (swrst_ack),
    .rstout_n  (rstout_n),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t n;
    n.state = M_HOLD; n.low_len = 0; n.idle = 0;
    n.lr0 = 0; n.lr1 = 0; n.lr2 = 0;
    n.cause = 2'b00; n.ack = 1'b0;
    return n;
  endfunction

  function automatic model_t model_step(model_t cur, logic b, logic req, logic kick);
    model_t n;
    bit pressed, wdt_fire;
    n = cur;
    n.ack = 1'b0;
    pressed  = (cur.lr2 >= DEB);
    wdt_fire = 1'b0;
    n.lr2 = cur.lr1;
    n.lr1 = cur.lr0;
    n.lr0 = (b === 1'b0) ? ((cur.lr0 < 1000) ? cur.lr0 + 1 : cur.lr0) : 0;
    if (cur.state == M_HOLD) begin
      n.low_len = cur.low_len + 1;
      n.idle    = 0;
      if (n.low_len >= HOLD && !pressed) n.state = M_RUN;
    end else begin
      n.idle = kick ? 0 : cur.idle + 1;
      if (WDT_ON && !kick && n.idle >= WDT) wdt_fire = 1'b1;
      if (pressed || wdt_fire || req) begin
        n.state   = M_HOLD;
        n.low_len = 0;
        n.idle    = 0;
        n.cause   = pressed ? 2'b01 : (wdt_fire ? 2'b11 : 2'b10);
        n.ack     = !pressed && !wdt_fire;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_step(m, btn_n, swrst_req, wdt_kick);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic r, input logic k);
    @(negedge clk);
    #2;
    btn_n     = b;
    swrst_req = r;
    wdt_kick  = k | (auto_kick && (cyc % 200 == 0));
    cyc++;
  endtask

  task automatic waitRun(input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (rstout_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("wait_run_timeout", 32'd0, 32'd1);
  endtask

  task automatic buttonPress(input int len, input int exp_width);
    int fall_at = -1;
    for (int i = 1; i <= len; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (fall_at < 0 && rstout_n === 1'b0) fall_at = i - 1;
    end
    waitRun(200);
    checkOutput("btn_fall_delay", fall_at, 19);
    checkOutput("btn_low_width", last_width, exp_width);
    checkOutput("btn_cause", rst_cause, 2'b01);
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("rstout_n", rstout_n, (m.state == M_RUN));
      checkOutput("rst_cause", rst_cause, m.cause);
      checkOutput("swrst_ack", swrst_ack, m.ack);
    end
  end

  // Observed low widths, falls from RUN and ack pulses.
  initial begin
    logic prev_out = 1'b0;
    forever begin
      @(negedge clk);
      if (swrst_ack === 1'b1) ack_count++;
      if (rst_n !== 1'b1) begin
        low_run = 0;
      end else if (rstout_n === 1'b0) begin
        if (prev_out === 1'b1) fall_count++;
        low_run++;
      end else begin
        if (low_run > 0) last_width = low_run;
        low_run = 0;
      end
      prev_out = rstout_n;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got 0, expected 1");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int snap, snap_ack, fell, run_left;
    bit b;

    rst_n = 1'b1; btn_n = 1'b1; swrst_req = 1'b0; wdt_kick = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_en = 1'b1;

    // Power-on
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    waitRun(100);
    checkOutput("por_low_width", last_width, HOLD);
    checkOutput("por_cause", rst_cause, 2'b00);
    checkOutput("por_no_ack", ack_count, 0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

    // Short glitch is filtered
    snap = fall_count;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (30) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("glitch_no_reset", fall_count - snap, 0);

    buttonPress(40, 32);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
    buttonPress(80, 65);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

    // Software request, then a second one ignored during HOLD
    snap_ack = ack_count;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sw_ack_first", swrst_ack, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sw_ack_second", swrst_ack, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitRun(100);
    checkOutput("sw_low_width", last_width, HOLD);
    checkOutput("sw_cause", rst_cause, 2'b10);
    checkOutput("sw_ack_count", ack_count - snap_ack, 1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

    // Debounce completes together with a software request: button wins
    snap_ack = ack_count;
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    waitRun(100);
    checkOutput("coincide_cause", rst_cause, 2'b01);
    checkOutput("coincide_no_ack", ack_count - snap_ack, 0);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

    // Level-held request re-triggers after the pulse
    snap_ack = ack_count;
    repeat (40) applyStimulus(1'b1, 1'b1, 1'b0);
    waitRun(100);
    checkOutput("held_req_acks", ack_count - snap_ack, 2);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

    // rst_n asserted mid-HOLD
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_cause", rst_cause, 2'b00);
    checkOutput("midrst_rstout", rstout_n, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    waitRun(100);
    checkOutput("midrst_low_width", last_width, HOLD);
    checkOutput("midrst_cause_after", rst_cause, 2'b00);

    // Randomized mix against the model
    run_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run_left == 0 && $urandom_range(0, 29) == 0) run_left = $urandom_range(1, 40);
      b = (run_left == 0);
      if (run_left > 0) run_left--;
      applyStimulus(b, ($urandom_range(0, 24) == 0), ($urandom_range(0, 149) == 0));
    end
    repeat (25) applyStimulus(1'b1, 1'b0, 1'b0);
    waitRun(200);

    // Watchdog: no kicks after a fresh RUN entry
    auto_kick = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitRun(100);
    fell = 0;
    for (int i = 1; i <= 1100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (rstout_n === 1'b0) begin
        fell = i;
        break;
      end
    end
    if (WDT_ON) begin
      checkOutput("wdt_expiry_cycles", fell, WDT);
      checkOutput("wdt_cause", rst_cause, 2'b11);
    end else begin
      checkOutput("nowdt_no_reset", fell, 0);
      checkOutput("nowdt_cause", rst_cause, 2'b10);
    end
    waitRun(100);

    // Regular kicks keep the board running
    snap = fall_count;
    for (int i = 0; i < 5000; i++) applyStimulus(1'b1, 1'b0, (i % 500 == 0));
    checkOutput("kicked_no_reset", fall_count - snap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
